// File: rtl/itcm_pkg.sv
// Shared definitions for the ITCM/DTCM ICB responders.
// State encoding, ICB width and lane/byte constants.
package itcm_pkg;

  typedef enum logic [1:0] {
    ITCM_IDLE = 2'd0,
    ITCM_ACC  = 2'd1,
    ITCM_RSP  = 2'd2
  } itcm_state_e;

  localparam int ICB_DW    = 32;
  localparam int ICB_BYTES = ICB_DW / 8;
  localparam int RAM_DW    = 2 * ICB_DW;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

endpackage

// File: rtl/itcm_wmask_merge.sv
// Byte-masked merge of a 32-bit ICB write into one lane
// of a 64-bit RAM word, for read-modify-write.
module itcm_wmask_merge
  import itcm_pkg::*;
(
  input  logic [RAM_DW-1:0]    i_old,
  input  logic [ICB_DW-1:0]    i_wdata,
  input  logic [ICB_BYTES-1:0] i_wmask,
  input  logic                 i_lane,
  output logic [RAM_DW-1:0]    o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int b = 0; b < ICB_BYTES; b++) begin
      if (i_wmask[b]) begin
        if (i_lane == LANE_HI)
          o_merged[ICB_DW+8*b +: 8] = i_wdata[8*b +: 8];
        else
          o_merged[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/itcm_icb_slave.sv
// ICB responder for the 64-bit ITCM RAM; sub-word
// writes are done as read-modify-write in one ACC cycle.
module itcm_icb_slave
  import itcm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int ICB_AW     = ADDR_WIDTH + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icb_cmd_valid,
  output logic                  icb_cmd_ready,
  input  logic [ICB_AW-1:0]     icb_cmd_addr,
  input  logic                  icb_cmd_read,
  input  logic [ICB_DW-1:0]     icb_cmd_wdata,
  input  logic [ICB_BYTES-1:0]  icb_cmd_wmask,
  output logic                  icb_rsp_valid,
  input  logic                  icb_rsp_ready,
  output logic [ICB_DW-1:0]     icb_rsp_rdata,
  output logic                  icb_rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  itcm_state_e r_state;
  itcm_state_e w_next;

  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_lane;
  logic                  r_read;
  logic [ICB_DW-1:0]     r_wdata;
  logic [ICB_BYTES-1:0]  r_wmask;
  logic [ICB_DW-1:0]     r_rdata;
  logic                  r_err;

  logic                  w_acc;
  logic                  w_mis;
  logic [ICB_DW-1:0]     w_lane_rd;
  logic [RAM_DW-1:0]     w_merged;

  assign w_acc = icb_cmd_valid & icb_cmd_ready;
  assign w_mis = |icb_cmd_addr[1:0];

  assign w_lane_rd = (r_lane == LANE_HI) ?
                     ram_rd_data[RAM_DW-1:ICB_DW] :
                     ram_rd_data[ICB_DW-1:0];

  itcm_wmask_merge u_merge (
    .i_old    (ram_rd_data),
    .i_wdata  (r_wdata),
    .i_wmask  (r_wmask),
    .i_lane   (r_lane),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ITCM_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ITCM_IDLE: if (w_acc) w_next = w_mis ? ITCM_RSP : ITCM_ACC;
      ITCM_ACC:  w_next = ITCM_RSP;
      ITCM_RSP: begin
        if (icb_rsp_ready)
          w_next = !w_acc ? ITCM_IDLE :
                   w_mis  ? ITCM_RSP  : ITCM_ACC;
      end
      default:   w_next = ITCM_IDLE;
    endcase
  end

  // Outside ACC the RAM address tracks the ICB command so
  // read data is ready in the ACC cycle that follows.
  always_comb begin
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b0;
    ram_wr_en     = 1'b0;
    ram_addr      = icb_cmd_addr[ICB_AW-1:3];
    ram_wr_data   = '0;
    unique case (r_state)
      ITCM_IDLE: icb_cmd_ready = 1'b1;
      ITCM_ACC: begin
        ram_addr = r_idx;
        if (!r_read) begin
          ram_wr_en   = !rst;
          ram_wr_data = w_merged;
        end
      end
      ITCM_RSP: begin
        icb_rsp_valid = 1'b1;
        icb_cmd_ready = icb_rsp_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_lane  <= 1'b0;
      r_read  <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_idx   <= icb_cmd_addr[ICB_AW-1:3];
      r_lane  <= icb_cmd_addr[2];
      r_read  <= icb_cmd_read;
      r_wdata <= icb_cmd_wdata;
      r_wmask <= icb_cmd_wmask;
      r_rdata <= '0;
      r_err   <= w_mis;
    end else if (r_state == ITCM_ACC) begin
      r_rdata <= r_read ? w_lane_rd : '0;
      r_err   <= 1'b0;
    end
  end

  assign icb_rsp_rdata = r_rdata;
  assign icb_rsp_err   = r_err;

endmodule

// File: tb/tb_itcm_icb_slave.sv
// Scoreboard bench for itcm_icb_slave with a byte-array
// reference model and a behavioural 1-cycle RAM.
module tb_itcm_icb_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic [14:0] icb_cmd_addr = '0;
  logic        icb_cmd_read = 1'b0;
  logic [31:0] icb_cmd_wdata = '0;
  logic [3:0]  icb_cmd_wmask = '0;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b1;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic [11:0] ram_addr;
  logic [63:0] ram_wr_data;
  logic        ram_wr_en;
  logic [63:0] ram_rd_data = '0;

  itcm_icb_slave dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .ram_addr      (ram_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_wr_en     (ram_wr_en),
    .ram_rd_data   (ram_rd_data)
  );

  always #5 clk = ~clk;

  logic [63:0] ram [0:4095];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_addr];
  end

  logic [7:0] rb [0:32767];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int wr_expect = 0;
  int last_acc_cyc = 0;
  int last_pop_cyc = -1;
  bit seen = 0;
  bit rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd32(input int a);
    return {rb[a+3], rb[a+2], rb[a+1], rb[a]};
  endfunction

  function automatic logic [63:0] rd64(input int w);
    return {rd32(w*8+4), rd32(w*8)};
  endfunction

  always @(negedge clk) begin
    if (ram_wr_en) wr_cnt++;
    if (!rst && icb_rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        if (!seen) begin
          seen = 1;
          chk("rsp_latency", 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
        end
        chk("rsp_rdata", {32'd0, icb_rsp_rdata}, {32'd0, q[0].rdata});
        chk("rsp_err", {63'd0, icb_rsp_err}, {63'd0, q[0].err});
        if (!icb_rsp_ready)
          chk("cmd_ready_stall", {63'd0, icb_cmd_ready}, 64'd0);
        else begin
          void'(q.pop_front());
          seen = 0;
          last_pop_cyc = cyc;
        end
      end
    end
  end

  task automatic issue(input logic [14:0] a, input logic rd,
                       input logic [31:0] wd, input logic [3:0] wm);
    exp_t e;
    int n;
    int ia;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = a;
    icb_cmd_read  = rd;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    n = 0;
    @(negedge clk);
    while (!icb_cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!icb_cmd_ready) begin
      chk("cmd_accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1 icb_cmd_valid = 1'b0;
      return;
    end
    ia = int'(a);
    e.acc_cyc = cyc;
    if (a[1:0] != 2'b00) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 1;
    end else if (rd) begin
      e.rdata = rd32(ia); e.err = 1'b0; e.lat = 2;
    end else begin
      for (int b = 0; b < 4; b++)
        if (wm[b]) rb[ia+b] = wd[8*b +: 8];
      e.rdata = '0; e.err = 1'b0; e.lat = 2;
      wr_expect++;
    end
    q.push_back(e);
    last_acc_cyc = cyc;
    @(posedge clk);
    #1 icb_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      n++;
      @(posedge clk);
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) icb_rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_acc;
    int wc;
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    for (int i = 0; i < 32768; i++) rb[i] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
    chk("rst_rdata", {32'd0, icb_rsp_rdata}, 64'd0);
    chk("rst_err", {63'd0, icb_rsp_err}, 64'd0);
    chk("rst_wr_en", {63'd0, ram_wr_en}, 64'd0);
    chk("rst_ram_addr", {52'd0, ram_addr}, 64'd0);
    chk("rst_wr_data", ram_wr_data, 64'd0);
    chk("rst_cmd_ready", {63'd0, icb_cmd_ready}, 64'd1);
    @(posedge clk);
    #1;

    issue(15'h0000, 1'b0, 32'h11223344, 4'hF);
    issue(15'h0004, 1'b0, 32'h55667788, 4'hF);
    issue(15'h0000, 1'b1, 32'h0, 4'h0);
    issue(15'h0004, 1'b1, 32'h0, 4'h0);
    drain();
    chk("word0_full", ram[0], 64'h5566778811223344);

    issue(15'h0004, 1'b0, 32'hAABBCCDD, 4'h5);
    issue(15'h0004, 1'b1, 32'h0, 4'h0);
    issue(15'h0000, 1'b1, 32'h0, 4'h0);
    drain();
    chk("word0_partial", ram[0], 64'h55BB77DD11223344);
    chk("model_partial", {32'd0, rd32(4)}, 64'h55BB77DD);

    wc = wr_cnt;
    issue(15'h0002, 1'b1, 32'h0, 4'h0);
    issue(15'h0003, 1'b0, 32'hFFFFFFFF, 4'hF);
    drain();
    chk("misaligned_no_write", 64'(wr_cnt - wc), 64'd0);
    chk("misaligned_mem", ram[0], 64'h55BB77DD11223344);

    icb_rsp_ready = 1'b0;
    issue(15'h0004, 1'b1, 32'h0, 4'h0);
    repeat (6) @(posedge clk);
    #1 icb_rsp_ready = 1'b1;
    issue(15'h0000, 1'b1, 32'h0, 4'h0);
    chk("release_same_cycle", 64'(last_acc_cyc), 64'(last_pop_cyc));
    drain();

    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = 15'h0008;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = 32'hDEADBEEF;
    icb_cmd_wmask = 4'hF;
    @(negedge clk);
    chk("acc_rst_accept", {63'd0, icb_cmd_ready}, 64'd1);
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("acc_rst_wr_en", {63'd0, ram_wr_en}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    icb_cmd_addr = '0;
    @(negedge clk);
    chk("acc_rst_valid", {63'd0, icb_rsp_valid}, 64'd0);
    chk("acc_rst_rdata", {32'd0, icb_rsp_rdata}, 64'd0);
    chk("acc_rst_err", {63'd0, icb_rsp_err}, 64'd0);
    chk("acc_rst_ready", {63'd0, icb_cmd_ready}, 64'd1);
    chk("acc_rst_wr_data", ram_wr_data, 64'd0);
    chk("acc_rst_mem", ram[1], 64'd0);
    @(posedge clk);
    #1;
    issue(15'h0008, 1'b1, 32'h0, 4'h0);
    drain();

    rand_rdy = 1;
    for (int k = 0; k < 400; k++) begin
      logic [14:0] a;
      a = 15'(($urandom_range(0, 31) << 3) | ($urandom_range(0, 1) << 2));
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end
    rand_rdy = 0;
    @(posedge clk);
    #1 icb_rsp_ready = 1'b1;
    drain();

    first_acc = -1;
    for (int i = 0; i < 4096; i++) begin
      issue(15'(i << 3), 1'b0, 32'(i), 4'hF);
      if (first_acc < 0) first_acc = last_acc_cyc;
      issue(15'((i << 3) | 4), 1'b0, 32'(i) ^ 32'hA5A50000, 4'hF);
    end
    for (int i = 0; i < 4096; i++) begin
      issue(15'(i << 3), 1'b1, 32'h0, 4'h0);
      issue(15'((i << 3) | 4), 1'b1, 32'h0, 4'h0);
    end
    chk("fill_throughput", 64'(last_acc_cyc - first_acc),
        64'(2 * (16384 - 1)));
    drain();
    chk("fill_word_last", ram[4095], rd64(4095));
    chk("wr_en_count", 64'(wr_cnt), 64'(wr_expect));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
